// File: rtl/lfsr_seq_checker_if.sv
// Sample/control bundle between an LFSR counter tap point and its sequence checker.
// The master drives samples and clear; the slave returns lock, error and period status.
interface lfsr_seq_checker_if #(
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic [1:N]       state_i;
  logic             clear_i;
  logic             locked_o;
  logic             err_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] period_o;
  logic             zero_o;

  modport master (
    output valid_i, state_i, clear_i,
    input  locked_o, err_o, err_cnt_o, period_o, zero_o
  );

  modport slave (
    input  valid_i, state_i, clear_i,
    output locked_o, err_o, err_cnt_o, period_o, zero_o
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Checks that successive samples of an N-bit LFSR counter follow the Fibonacci successor rule.
// Acquires lock, counts sequence errors, measures the period and flags the all-zero lock-up state.
module lfsr_seq_checker #(
  parameter int         N        = 3,
  parameter int         TAP_A    = 3,
  parameter int         TAP_B    = 2,
  parameter logic [1:N] SEED     = 'b1,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 3,
  parameter int         CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  lfsr_seq_checker_if.slave  bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  // Counters compare against the value before the final increment, so they never exceed LOCK_CNT-1 / LOSS_CNT-1.
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} fsm_e;

  fsm_e             state_q, state_d;
  logic [1:N]       prev_q, prev_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic             seed_seen_q, seed_seen_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             zero_q, zero_d;

  logic [1:N] pred;
  logic       is_zero;
  logic       match;

  assign pred    = {prev_q[TAP_A] ^ prev_q[TAP_B], prev_q[1:N-1]};
  assign is_zero = (bus.state_i == '0);
  assign match   = (bus.state_i == pred) && !is_zero;

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through this block can infer a latch.
    state_d     = state_q;
    prev_d      = prev_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    per_cnt_d   = per_cnt_q;
    seed_seen_d = seed_seen_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    period_d    = period_q;
    zero_d      = zero_q;

    if (bus.valid_i) begin
      prev_d = bus.state_i;
      if (is_zero) zero_d = 1'b1;
      unique case (state_q)
        HUNT: begin
          match_cnt_d = '0;
          state_d     = VERIFY;
        end
        VERIFY: begin
          if (!match) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == LOCK_LAST) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            per_cnt_d   = '0;
            seed_seen_d = 1'b0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          // A saturated period counter means the measurement is unusable, so period_q is left alone.
          if (bus.state_i == SEED) begin
            if (seed_seen_q && (per_cnt_q != '1)) period_d = per_cnt_q + 1'b1;
            per_cnt_d   = '0;
            seed_seen_d = 1'b1;
          end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + 1'b1;
          end

          if (match) begin
            miss_cnt_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (miss_cnt_q == LOSS_LAST) begin
              state_d     = HUNT;
              miss_cnt_d  = '0;
              per_cnt_d   = '0;
              seed_seen_d = 1'b0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear overrides any same-cycle update of the counters it owns; the err pulse still fires.
    if (bus.clear_i) begin
      err_cnt_d = '0;
      period_d  = '0;
      zero_d    = 1'b0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      per_cnt_q   <= '0;
      seed_seen_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      period_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      per_cnt_q   <= per_cnt_d;
      seed_seen_q <= seed_seen_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      period_q    <= period_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.locked_o  = locked_q;
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = err_cnt_q;
  assign bus.period_o  = period_q;
  assign bus.zero_o    = zero_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: directed scenarios plus random stimulus,
// compared against a table-driven reference model of the 3-bit sequence.
module tb_lfsr_seq_checker;

  localparam int         LOCK_CNT = 4;
  localparam int         LOSS_CNT = 3;
  localparam logic [2:0] SEED     = 3'b001;
  localparam logic [2:0] SEQ [7]  = '{3'b001, 3'b100, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011};
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  lfsr_seq_checker_if #(.N(3), .CNT_W(8)) bus ();

  lfsr_seq_checker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_state;
  logic [2:0] m_prev;
  int         m_run, m_miss, m_per;
  bit         m_seen, m_err, m_zero;
  int         m_err_cnt, m_period;

  int         pos;
  logic [2:0] last_fed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] succ(input logic [2:0] x);
    for (int i = 0; i < 7; i++)
      if (SEQ[i] == x) return SEQ[(i + 1) % 7];
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_state = M_HUNT; m_prev = 3'b000; m_run = 0; m_miss = 0; m_per = 0;
    m_seen = 0; m_err = 0; m_zero = 0; m_err_cnt = 0; m_period = 0;
  endtask

  task automatic model_step(input bit v, input logic [2:0] s, input bit clr);
    bit ok;
    m_err = 0;
    if (v) begin
      ok = (s != 3'b000) && (s == succ(m_prev));
      if (s == 3'b000) m_zero = 1;
      if (m_state == M_HUNT) begin
        m_state = M_VERIFY;
        m_run   = 0;
      end else if (m_state == M_VERIFY) begin
        m_run = ok ? m_run + 1 : 0;
        if (m_run == LOCK_CNT) begin
          m_state = M_LOCKED; m_miss = 0; m_per = 0; m_seen = 0;
        end
      end else begin
        if (s == SEED) begin
          if (m_seen && m_per < 255) m_period = m_per + 1;
          m_per  = 0;
          m_seen = 1;
        end else if (m_per < 255) begin
          m_per = m_per + 1;
        end
        if (ok) begin
          m_miss = 0;
        end else begin
          m_err = 1;
          if (m_err_cnt < 255) m_err_cnt = m_err_cnt + 1;
          m_miss = m_miss + 1;
          if (m_miss == LOSS_CNT) begin
            m_state = M_HUNT; m_miss = 0; m_seen = 0;
          end
        end
      end
      m_prev = s;
    end
    if (clr) begin
      m_err_cnt = 0; m_zero = 0; m_period = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".locked"},  32'(bus.locked_o),  32'(m_state == M_LOCKED));
    check({tag, ".err"},     32'(bus.err_o),     32'(m_err));
    check({tag, ".err_cnt"}, 32'(bus.err_cnt_o), 32'(m_err_cnt));
    check({tag, ".period"},  32'(bus.period_o),  32'(m_period));
    check({tag, ".zero"},    32'(bus.zero_o),    32'(m_zero));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".locked"},  32'(bus.locked_o),  32'd0);
    check({tag, ".err"},     32'(bus.err_o),     32'd0);
    check({tag, ".err_cnt"}, 32'(bus.err_cnt_o), 32'd0);
    check({tag, ".period"},  32'(bus.period_o),  32'd0);
    check({tag, ".zero"},    32'(bus.zero_o),    32'd0);
  endtask

  task automatic step(input bit v, input logic [2:0] s, input bit clr, input string tag);
    @(negedge clk);
    bus.valid_i = v;
    bus.state_i = s;
    bus.clear_i = clr;
    @(posedge clk);
    #1;
    model_step(v, s, clr);
    check_outputs(tag);
  endtask

  task automatic feed_good(input string tag);
    last_fed = SEQ[pos % 7];
    pos++;
    step(1'b1, last_fed, 1'b0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    bus.valid_i = 1'b0;
    bus.state_i = 3'b000;
    bus.clear_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    pos     = 0;
  endtask

  initial begin
    int         pulses;
    int         nv;
    logic [2:0] bad;
    logic [2:0] s;

    bus.valid_i = 1'b0;
    bus.state_i = 3'b000;
    bus.clear_i = 1'b0;
    model_reset();

    // Scenario 1: clean sequence, valid every cycle
    do_reset();
    for (int k = 0; k < 15; k++) begin
      feed_good("seq");
      if (k == 3) check("lock_before_5th", 32'(bus.locked_o), 32'd0);
      if (k == 4) check("lock_at_5th", 32'(bus.locked_o), 32'd1);
    end
    check("period_clean", 32'(bus.period_o), 32'd7);
    check("errcnt_clean", 32'(bus.err_cnt_o), 32'd0);

    // Scenario 2: one 101 replaced by 000
    while (SEQ[pos % 7] != 3'b101) feed_good("pre_zero");
    pos++;
    step(1'b1, 3'b000, 1'b0, "zero_inj");
    pulses = int'(bus.err_o);
    for (int k = 0; k < 3; k++) begin
      feed_good("post_zero");
      pulses += int'(bus.err_o);
    end
    check("zero_pulses", 32'(pulses), 32'd2);
    check("zero_errcnt", 32'(bus.err_cnt_o), 32'd2);
    check("zero_flag", 32'(bus.zero_o), 32'd1);
    check("zero_lock_held", 32'(bus.locked_o), 32'd1);

    // Scenario 3: clear, then frozen counter drops lock, then relock
    step(1'b0, 3'b000, 1'b1, "clear_idle");
    check("clear_errcnt", 32'(bus.err_cnt_o), 32'd0);
    check("clear_zero", 32'(bus.zero_o), 32'd0);
    check("clear_period", 32'(bus.period_o), 32'd0);
    do feed_good("pre_freeze"); while (last_fed != 3'b010);
    for (int k = 0; k < 3; k++) step(1'b1, 3'b010, 1'b0, "freeze");
    check("freeze_errcnt", 32'(bus.err_cnt_o), 32'd3);
    check("freeze_unlock", 32'(bus.locked_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      feed_good("relock");
      if (k == 3) check("relock_before", 32'(bus.locked_o), 32'd0);
    end
    check("relock_after", 32'(bus.locked_o), 32'd1);

    // Scenario 4: valid toggling 1/0 with junk on idle cycles
    do_reset();
    nv = 0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) begin
        feed_good("toggle_v");
        nv++;
        if (nv == 5) check("toggle_lock", 32'(bus.locked_o), 32'd1);
      end else begin
        step(1'b0, 3'($urandom_range(0, 7)), 1'b0, "toggle_idle");
      end
      pulses += int'(bus.err_o);
    end
    check("toggle_period", 32'(bus.period_o), 32'd7);
    check("toggle_errcnt", 32'(bus.err_cnt_o), 32'd0);
    check("toggle_pulses", 32'(pulses), 32'd0);

    // Scenario 5: random mix of good, bad, zero, idle and clear
    for (int k = 0; k < 600; k++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 14)       s = (m_prev == 3'b000) ? SEQ[$urandom_range(0, 6)] : succ(m_prev);
      else if (r < 16)  s = 3'b000;
      else              s = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 9) < 8), s, ($urandom_range(0, 49) == 0), "rand");
    end

    // Scenario 6: saturate the error counter, then clear together with an error
    do_reset();
    for (int k = 0; k < 5; k++) feed_good("sat_lock");
    for (int k = 0; k < 260; k++) begin
      do bad = 3'($urandom_range(1, 7)); while (bad == succ(m_prev));
      step(1'b1, bad, 1'b0, "sat_bad");
      step(1'b1, succ(bad), 1'b0, "sat_good");
    end
    check("sat_errcnt", 32'(bus.err_cnt_o), 32'd255);
    check("sat_lock", 32'(bus.locked_o), 32'd1);
    do bad = 3'($urandom_range(1, 7)); while (bad == succ(m_prev));
    step(1'b1, bad, 1'b1, "clr_err");
    check("clr_err_pulse", 32'(bus.err_o), 32'd1);
    check("clr_err_cnt", 32'(bus.err_cnt_o), 32'd0);

    // Scenario 7: asynchronous reset mid-lock
    for (int k = 0; k < 3; k++) step(1'b1, succ(m_prev), 1'b0, "pre_areset");
    check("pre_areset_lock", 32'(bus.locked_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("areset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pos = 0;
    for (int k = 0; k < 5; k++) feed_good("areset_relock");
    check("areset_relock_lock", 32'(bus.locked_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
